aes_key_sched_ctrl: RTL and testbench

Sequencer for the AES-128 round-key datapath. It accepts a cipher key and streams the 11 round keys to the round pipeline over a valid/ready handshake. Encryption order is 0..10, produced by the forward key step. Decryption order is 10..0: the block first expands forward to round key 10, then walks back with the inverse key step (aes_inv_key_shedualing). Both step units are instantiated inside this block and time-shared under FSM control.

---
 rtl/aes_key_sched_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 round-key sequencer, forward (enc) and reverse (dec) order
module aes_key_sched_ctrl #(
  parameter int          NR         = 10,
  parameter logic [7:0]  RCON_FIRST = 8'h01,
  parameter logic [7:0]  RCON_LAST  = 8'h36
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_i,
  input  logic         dec_i,
  input  logic         abort_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_last_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, PREP, STREAM} state_t;

  localparam logic [3:0] LAST_IDX  = 4'(NR);
  localparam logic [3:0] PREP_LAST = 4'(NR - 1);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? ({1'b0, x[7:1]} ^ 8'h8d) : {1'b0, x[7:1]};
  endfunction

  function automatic logic [127:0] aes_fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: recover the previous words from the XOR chain, then w0.
  function automatic logic [127:0] aes_inv_key_shedualing(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  state_t       state, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         dec_q, dec_d;

  logic [127:0] fwd_key, inv_key;
  logic [7:0]   fwd_rcon, inv_rcon;
  logic         streaming, is_last, accept;

  always_comb begin
    fwd_key  = aes_fwd_key_step(key_q, rcon_q);
    fwd_rcon = xtime(rcon_q);
  end

  always_comb begin
    inv_key  = aes_inv_key_shedualing(key_q, rcon_q);
    inv_rcon = inv_xtime(rcon_q);
  end

  assign streaming   = (state == STREAM);
  assign is_last     = dec_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX);
  assign accept      = streaming && rk_ready_i;

  assign key_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign rk_valid_o  = streaming;
  assign rk_o        = streaming ? key_q : '0;
  assign rk_idx_o    = streaming ? idx_q : '0;
  assign rk_last_o   = streaming && is_last;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state  <= IDLE;
      key_q  <= '0;
      rcon_q <= RCON_FIRST;
      idx_q  <= '0;
      cnt_q  <= '0;
      dec_q  <= 1'b0;
    end else begin
      state  <= state_d;
      key_q  <= key_d;
      rcon_q <= rcon_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      dec_q  <= dec_d;
    end
  end

  always_comb begin
    state_d = state;
    key_d   = key_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    case (state)
      IDLE: begin
        if (key_valid_i) begin
          key_d  = key_i;
          rcon_d = RCON_FIRST;
          dec_d  = dec_i;
          if (dec_i) begin
            state_d = PREP;
            cnt_d   = '0;
          end else begin
            state_d = STREAM;
            idx_d   = '0;
          end
        end
      end
      PREP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          key_d  = fwd_key;
          rcon_d = fwd_rcon;
          cnt_d  = cnt_q + 4'd1;
          // Reverse walk starts from the last round key and the last rcon.
          if (cnt_q == PREP_LAST) begin
            state_d = STREAM;
            idx_d   = LAST_IDX;
            rcon_d  = RCON_LAST;
          end
        end
      end
      STREAM: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (accept) begin
          if (is_last) begin
            state_d = IDLE;
          end else if (dec_q) begin
            key_d  = inv_key;
            rcon_d = inv_rcon;
            idx_d  = idx_q - 4'd1;
          end else begin
            key_d  = fwd_key;
            rcon_d = fwd_rcon;
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         key_valid_i = 1'b0;
  logic         key_ready_o;
  logic [127:0] key_i = '0;
  logic         dec_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         rk_valid_o;
  logic         rk_ready_i = 1'b0;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_last_o;
  logic         busy_o;

  aes_key_sched_ctrl dut (
    .clk(clk), .nreset(nreset),
    .key_valid_i(key_valid_i), .key_ready_o(key_ready_o), .key_i(key_i), .dec_i(dec_i),
    .abort_i(abort_i),
    .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i), .rk_o(rk_o),
    .rk_idx_o(rk_idx_o), .rk_last_o(rk_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] idx; logic [127:0] key; logic last; } beat_t;
  typedef struct { logic dec; logic [127:0] key; int pct; } vec_t;
  typedef struct { logic [127:0] key; int idx; logic [127:0] val; } kat_t;

  beat_t        exp_q[$];
  vec_t         vecs[6];
  kat_t         kats[9];
  logic [7:0]   sbox_t[256];
  logic [127:0] mrk[11];
  logic [127:0] zrk[11];
  logic [127:0] got_rk[11];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box built from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= NR; r++) mrk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!key_ready_o && g < 100) begin
      tick();
      g++;
    end
    check("idle_wait", 128'(key_ready_o), 128'(1));
  endtask

  task automatic run_seq(input logic d, input logic [127:0] k, input int pct);
    beat_t b;
    int lat, cyc;
    logic stalled, hl;
    logic [127:0] hk;
    logic [3:0] hi;
    model_expand(k);
    exp_q.delete();
    for (int i = 0; i <= NR; i++) begin
      got_rk[i] = 'x;
      b.idx  = d ? 4'(NR - i) : 4'(i);
      b.key  = mrk[b.idx];
      b.last = (i == NR);
      exp_q.push_back(b);
    end
    wait_idle();
    key_valid_i = 1'b1; key_i = k; dec_i = d;
    tick();
    key_valid_i = 1'b0;
    lat = 0;
    while (!rk_valid_o && lat < 40) begin
      check("prep_busy", 128'(busy_o), 128'(1));
      tick();
      lat++;
    end
    check("first_latency", 128'(lat), d ? 128'(NR) : 128'(0));
    cyc = 0; stalled = 1'b0; hk = '0; hi = '0; hl = 1'b0;
    while (exp_q.size() > 0 && cyc < 400) begin
      rk_ready_i = ($urandom_range(99) < pct);
      if (stalled) begin
        check("stall_key", rk_o, hk);
        check("stall_idx", 128'(rk_idx_o), 128'(hi));
        check("stall_last", 128'(rk_last_o), 128'(hl));
      end
      if (rk_valid_o && rk_ready_i) begin
        b = exp_q.pop_front();
        check("beat_idx", 128'(rk_idx_o), 128'(b.idx));
        check("beat_key", rk_o, b.key);
        check("beat_last", 128'(rk_last_o), 128'(b.last));
        got_rk[b.idx] = rk_o;
        stalled = 1'b0;
      end else begin
        stalled = rk_valid_o;
        hk = rk_o; hi = rk_idx_o; hl = rk_last_o;
      end
      tick();
      cyc++;
    end
    rk_ready_i = 1'b0;
    check("sb_drained", 128'(exp_q.size()), 128'(0));
    check("ready_after_last", 128'(key_ready_o), 128'(1));
    check("valid_after_last", 128'(rk_valid_o), 128'(0));
    for (int j = 0; j < 9; j++)
      if (kats[j].key == k) check($sformatf("kat_idx%0d", kats[j].idx), got_rk[kats[j].idx], kats[j].val);
  endtask

  initial begin
    int g, seen;
    vecs[0] = '{1'b0, 128'h0, 100};
    vecs[1] = '{1'b1, 128'h0, 100};
    vecs[2] = '{1'b0, 128'h0, 50};
    vecs[3] = '{1'b0, FIPS_KEY, 100};
    vecs[4] = '{1'b1, FIPS_KEY, 50};
    vecs[5] = '{1'b1, {$urandom, $urandom, $urandom, $urandom}, 70};
    kats[0] = '{128'h0, 0,  128'h0};
    kats[1] = '{128'h0, 1,  128'h62636363626363636263636362636363};
    kats[2] = '{128'h0, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    kats[3] = '{128'h0, 8,  128'h0ef903333ba9613897060a04511dfa9f};
    kats[4] = '{128'h0, 9,  128'hb1d4d8e28a7db9da1d7bb3de4c664941};
    kats[5] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    kats[6] = '{FIPS_KEY, 0,  FIPS_KEY};
    kats[7] = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    kats[8] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    build_sbox();

    tick(); tick();
    check("rst_key_ready", 128'(key_ready_o), 128'(1));
    check("rst_valid", 128'(rk_valid_o), 128'(0));
    check("rst_rk", rk_o, 128'h0);
    check("rst_idx", 128'(rk_idx_o), 128'(0));
    check("rst_last", 128'(rk_last_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    nreset = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) run_seq(vecs[v].dec, vecs[v].key, vecs[v].pct);

    // Abort during PREP cycle 5: no key may ever come out.
    wait_idle();
    key_valid_i = 1'b1; key_i = FIPS_KEY; dec_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("prep5_busy", 128'(busy_o), 128'(1));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_prep_ready", 128'(key_ready_o), 128'(1));
    check("abort_prep_busy", 128'(busy_o), 128'(0));
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (rk_valid_o) seen++;
      tick();
    end
    check("abort_prep_novalid", 128'(seen), 128'(0));

    // Abort at STREAM idx4, then a fresh encrypt must restart from idx0.
    model_expand(128'h0);
    key_valid_i = 1'b1; key_i = 128'h0; dec_i = 1'b0; rk_ready_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    g = 0;
    while (!(rk_valid_o && rk_idx_o == 4'd4) && g < 30) begin
      check("abort_run_key", rk_o, mrk[rk_idx_o]);
      tick();
      g++;
    end
    check("abort_reached_idx4", 128'(rk_idx_o), 128'(4));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0; rk_ready_i = 1'b0;
    check("abort_stream_valid", 128'(rk_valid_o), 128'(0));
    check("abort_stream_ready", 128'(key_ready_o), 128'(1));
    run_seq(1'b0, FIPS_KEY, 100);

    // abort alone in IDLE is ignored; key plus abort in IDLE is accepted.
    abort_i = 1'b1;
    tick();
    check("idle_abort_busy", 128'(busy_o), 128'(0));
    key_valid_i = 1'b1; key_i = FIPS_KEY; dec_i = 1'b0;
    tick();
    key_valid_i = 1'b0; abort_i = 1'b0;
    check("key_abort_valid", 128'(rk_valid_o), 128'(1));
    check("key_abort_rk", rk_o, FIPS_KEY);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // Reset mid-STREAM of a decrypt at idx 6.
    wait_idle();
    key_valid_i = 1'b1; key_i = 128'h0; dec_i = 1'b1; rk_ready_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    g = 0;
    while (!(rk_valid_o && rk_idx_o == 4'd6) && g < 60) begin
      tick();
      g++;
    end
    check("rst_mid_idx6", 128'(rk_idx_o), 128'(6));
    nreset = 1'b0;
    tick();
    nreset = 1'b1; rk_ready_i = 1'b0;
    check("rstm_ready", 128'(key_ready_o), 128'(1));
    check("rstm_valid", 128'(rk_valid_o), 128'(0));
    check("rstm_rk", rk_o, 128'h0);
    check("rstm_idx", 128'(rk_idx_o), 128'(0));
    check("rstm_last", 128'(rk_last_o), 128'(0));
    check("rstm_busy", 128'(busy_o), 128'(0));
    tick();
    check("rstm_stays_idle", 128'(rk_valid_o), 128'(0));

    // Back-to-back: key_valid held; the second key waits for the first sequence's last beat.
    model_expand(128'h0);
    for (int i = 0; i <= NR; i++) zrk[i] = mrk[i];
    key_valid_i = 1'b1; key_i = 128'h0; dec_i = 1'b0; rk_ready_i = 1'b1;
    tick();
    key_i = FIPS_KEY;
    for (int i = 0; i <= NR; i++) begin
      check("b2b_idx", 128'(rk_idx_o), 128'(i));
      check("b2b_key", rk_o, zrk[i]);
      check("b2b_not_ready", 128'(key_ready_o), 128'(0));
      tick();
    end
    check("b2b_gap_ready", 128'(key_ready_o), 128'(1));
    check("b2b_gap_valid", 128'(rk_valid_o), 128'(0));
    tick();
    key_valid_i = 1'b0;
    model_expand(FIPS_KEY);
    check("b2b_second_idx", 128'(rk_idx_o), 128'(0));
    check("b2b_second_key", rk_o, FIPS_KEY);
    tick();
    check("b2b_second_k1", rk_o, mrk[1]);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0; rk_ready_i = 1'b0;
    check("b2b_end_idle", 128'(key_ready_o), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
